fetch_unit: RTL and testbench

Instruction fetch stage of the 16-bit CPU, sitting directly upstream of the opcode decoder/control block. It holds the PC and issues word-addressed reads to instruction memory over a req/ack handshake. It registers the returned 16-bit instruction and presents it, with opcode = instr[15:13], to decode under a valid/stall handshake. It accepts PC redirects for jump and taken branch, and drops any in-flight stale fetch.

---
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Brief    : Instruction-memory and decode-side signals of the fetch stage.
// Revision : 1.0  initial release
// ============================================================================
interface fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr;
    logic [2:0]  opcode;
    logic [15:0] instr_pc;
    logic        instr_valid;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  stall, redirect, redirect_pc,
        output instr, opcode, instr_pc, instr_valid
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output stall, redirect, redirect_pc,
        input  instr, opcode, instr_pc, instr_valid
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage. Holds the PC, reads instruction memory
//            over req/ack, presents the registered instruction to decode
//            under valid/stall and handles jump/branch redirects.
//            Optional one-entry prefetch buffer: define FETCH_PREFETCH_EN.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd1
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam logic [1:0] c_st_fetch = 2'd0;
    localparam logic [1:0] c_st_valid = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_armed;
    logic [15:0] r_pc;
    logic [15:0] r_drain_addr;
    logic [15:0] r_instr;
    logic [15:0] r_instr_pc;
    logic        r_instr_valid;
    logic        w_req;
    logic [15:0] w_addr;
    logic        w_hs;
    logic        w_pending;
`ifdef FETCH_PREFETCH_EN
    logic [15:0] r_buf;
    logic [15:0] r_buf_pc;
    logic        r_buf_valid;
`endif

    assign w_hs      = w_req & bus.imem_ack;
    assign w_pending = w_req & ~bus.imem_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.redirect) begin
            // An unanswered request must still be drained before refetching.
            w_state_nxt = w_pending ? c_st_drain : c_st_fetch;
        end else begin
            case (r_state)
                c_st_fetch: if (w_hs) w_state_nxt = c_st_valid;
                c_st_valid: begin
`ifdef FETCH_PREFETCH_EN
                    if (!bus.stall && !r_buf_valid && !w_hs) w_state_nxt = c_st_fetch;
`else
                    if (!bus.stall) w_state_nxt = c_st_fetch;
`endif
                end
                c_st_drain: if (w_hs) w_state_nxt = c_st_fetch;
                default:    w_state_nxt = c_st_fetch;
            endcase
        end
    end

    // r_armed keeps the request low for the first cycle out of reset.
    always_comb begin
        w_req  = 1'b0;
        w_addr = r_pc;
        case (r_state)
            c_st_fetch: w_req = r_armed;
            c_st_drain: begin
                w_req  = 1'b1;
                w_addr = r_drain_addr;
            end
`ifdef FETCH_PREFETCH_EN
            c_st_valid: w_req = ~r_buf_valid;
`endif
            default:    w_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed       <= 1'b0;
            r_pc          <= RESET_PC;
            r_drain_addr  <= RESET_PC;
            r_instr       <= 16'h0000;
            r_instr_pc    <= 16'h0000;
            r_instr_valid <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            r_buf         <= 16'h0000;
            r_buf_pc      <= 16'h0000;
            r_buf_valid   <= 1'b0;
`endif
        end else begin
            r_armed <= 1'b1;
            if (bus.redirect) begin
                r_pc          <= bus.redirect_pc;
                r_instr_valid <= 1'b0;
                if (w_pending && (r_state != c_st_drain)) r_drain_addr <= r_pc;
`ifdef FETCH_PREFETCH_EN
                r_buf_valid   <= 1'b0;
`endif
            end else begin
                case (r_state)
                    c_st_fetch: begin
                        if (w_hs) begin
                            r_instr       <= bus.imem_rdata;
                            r_instr_pc    <= r_pc;
                            r_pc          <= r_pc + PC_STEP;
                            r_instr_valid <= 1'b1;
                        end
                    end
                    c_st_valid: begin
`ifdef FETCH_PREFETCH_EN
                        if (!bus.stall) begin
                            if (r_buf_valid) begin
                                r_instr     <= r_buf;
                                r_instr_pc  <= r_buf_pc;
                                r_buf_valid <= 1'b0;
                            end else if (w_hs) begin
                                // Empty buffer: the returning word goes straight to decode.
                                r_instr    <= bus.imem_rdata;
                                r_instr_pc <= r_pc;
                                r_pc       <= r_pc + PC_STEP;
                            end else begin
                                r_instr_valid <= 1'b0;
                            end
                        end else if (w_hs) begin
                            r_buf       <= bus.imem_rdata;
                            r_buf_pc    <= r_pc;
                            r_buf_valid <= 1'b1;
                            r_pc        <= r_pc + PC_STEP;
                        end
`else
                        if (!bus.stall) r_instr_valid <= 1'b0;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = w_addr;
    assign bus.instr       = r_instr;
    assign bus.opcode      = r_instr[15:13];
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit: directed scenarios followed
//            by randomized stall/redirect/reset/latency against a
//            transaction-level model of the fetch stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
`ifdef FETCH_PREFETCH_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic clk;
    logic reset;
    fetch_unit_if bus_if ();

    fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(16'd1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit scramble = 1'b0;
    int lat_mode = 0;
    bit spur_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] memf(input logic [15:0] a);
        logic [15:0] t;
        t = a * 16'h9E37;
        return scramble ? (t ^ 16'h2000) : (16'h2000 + a);
    endfunction

    // Memory: latency 0..3 cycles per request, drops everything on reset.
    bit m_busy = 1'b0;
    int m_cnt  = 0;
    int m_lat  = 0;
    always @(posedge clk) begin
        #1;
        if (bus_if.imem_req) begin
            if (!m_busy) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_lat  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end
            bus_if.imem_ack = (m_cnt >= m_lat);
        end else begin
            bus_if.imem_ack = spur_en && ($urandom_range(0, 9) == 0);
        end
        bus_if.imem_rdata = (bus_if.imem_req && bus_if.imem_ack) ? memf(bus_if.imem_addr) : 16'($urandom);
    end
    always @(negedge clk) begin
        if (reset) m_busy = 1'b0;
        else if (bus_if.imem_req) begin
            if (bus_if.imem_ack) m_busy = 1'b0;
            else m_cnt++;
        end
    end

    // Model: instructions must reach decode in address order starting from
    // the last redirect (or reset) target, each carrying mem[address].
    logic [15:0] exp_fetch, exp_del, p_addr, e;
    bit stale = 1'b0, p_pend = 1'b0, p_redir = 1'b0, p_reset = 1'b0;
    int idle = 0;
    always @(negedge clk) begin
        if (reset) begin
            exp_fetch = RESET_PC;
            exp_del   = RESET_PC;
            stale = 1'b0; p_pend = 1'b0; p_redir = 1'b0; p_reset = 1'b1; idle = 0;
        end else begin
            if (p_reset) begin
                chk("post_reset_valid", bus_if.instr_valid, 0);
                chk("post_reset_req", bus_if.imem_req, 0);
            end
            if (p_redir) chk("post_redirect_valid", bus_if.instr_valid, 0);
            if (p_pend) begin
                chk("req_held", bus_if.imem_req, 1);
                chk("addr_stable", bus_if.imem_addr, p_addr);
            end
            if (bus_if.imem_req && bus_if.imem_ack && !stale && !bus_if.redirect) begin
                chk("fetch_addr", bus_if.imem_addr, exp_fetch);
                exp_fetch = exp_fetch + 16'd1;
            end
            if (bus_if.instr_valid) begin
                e = memf(exp_del);
                chk("instr_pc", bus_if.instr_pc, exp_del);
                chk("instr", bus_if.instr, e);
                chk("opcode", bus_if.opcode, e[15:13]);
`ifndef FETCH_PREFETCH_EN
                chk("no_req_while_valid", bus_if.imem_req, 0);
`endif
            end
            if (bus_if.instr_valid && !bus_if.stall && !bus_if.redirect) begin
                exp_del = exp_del + 16'd1;
                idle = 0;
            end else if (!bus_if.stall) begin
                idle++;
            end
            if (idle >= 60) begin
                chk("progress_idle_cycles", idle, 0);
                idle = 0;
            end
            if (bus_if.redirect) begin
                exp_fetch = bus_if.redirect_pc;
                exp_del   = bus_if.redirect_pc;
                idle = 0;
            end
            stale   = bus_if.imem_req && !bus_if.imem_ack && (stale || bus_if.redirect);
            p_pend  = bus_if.imem_req && !bus_if.imem_ack;
            p_addr  = bus_if.imem_addr;
            p_redir = bus_if.redirect;
            p_reset = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input int maxc);
        int n = 0;
        while (!bus_if.instr_valid && n < maxc) begin cyc(); n++; end
        chk("wait_valid_timeout", bus_if.instr_valid, 1);
    endtask

    task automatic wait_req(input logic [15:0] a, input int maxc);
        int n = 0;
        while (!(bus_if.imem_req && bus_if.imem_addr == a) && n < maxc) begin cyc(); n++; end
        chk("wait_req_timeout", bus_if.imem_addr, a);
    endtask

    task automatic do_redirect(input logic [15:0] a);
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = a;
        cyc();
        bus_if.redirect    = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus_if.stall = 1'b0; bus_if.redirect = 1'b0; bus_if.redirect_pc = 16'h0000;
        bus_if.imem_ack = 1'b0; bus_if.imem_rdata = 16'h0000;
        repeat (2) cyc();
        chk("rst_valid", bus_if.instr_valid, 0);
        chk("rst_req", bus_if.imem_req, 0);
        chk("rst_instr", bus_if.instr, 16'h0000);
        chk("rst_instr_pc", bus_if.instr_pc, 16'h0000);
        reset = 1'b0;

        // First fetch with single-cycle memory
        cyc();
        chk("first_req", bus_if.imem_req, 1);
        chk("first_addr", bus_if.imem_addr, 16'h0000);
        cyc();
        chk("first_valid", bus_if.instr_valid, 1);
        chk("first_instr", bus_if.instr, 16'h2000);
        chk("first_pc", bus_if.instr_pc, 16'h0000);
        chk("first_opcode", bus_if.opcode, 3'b001);
        n = 0;
        do begin cyc(); n++; end while (!(bus_if.instr_valid && bus_if.instr_pc == 16'h0001) && n < 10);
        chk("second_gap", n, GAP);
        chk("second_instr", bus_if.instr, 16'h2001);

        // Stall hold
        bus_if.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_valid", bus_if.instr_valid, 1);
            chk("stall_instr", bus_if.instr, 16'h2001);
            chk("stall_pc", bus_if.instr_pc, 16'h0001);
        end
        bus_if.stall = 1'b0;
        n = 0;
        do begin cyc(); n++; end while (!(bus_if.instr_valid && bus_if.instr_pc == 16'h0002) && n < 10);
        chk("resume_instr", bus_if.instr, 16'h2002);

        // Redirect while valid
        do_redirect(16'h0040);
        chk("redir_valid", bus_if.instr_valid, 0);
        chk("redir_req", bus_if.imem_req, 1);
        chk("redir_addr", bus_if.imem_addr, 16'h0040);
        wait_valid(20);
        chk("redir_pc", bus_if.instr_pc, 16'h0040);
        chk("redir_instr", bus_if.instr, 16'h2040);

        // Redirect while a 3-cycle fetch is outstanding
        lat_mode = 3;
        do_redirect(16'h0005);
        wait_req(16'h0005, 20);
        cyc();
        do_redirect(16'h0080);
        chk("drain_req", bus_if.imem_req, 1);
        chk("drain_addr", bus_if.imem_addr, 16'h0005);
        chk("drain_valid", bus_if.instr_valid, 0);
        wait_valid(30);
        chk("drain_first_pc", bus_if.instr_pc, 16'h0080);
        chk("drain_first_instr", bus_if.instr, 16'h2080);

        // PC wrap
        lat_mode = 0;
        do_redirect(16'hFFFF);
        wait_valid(30);
        chk("wrap_pc_ffff", bus_if.instr_pc, 16'hFFFF);
        chk("wrap_instr_ffff", bus_if.instr, 16'h1FFF);
        n = 0;
        do begin cyc(); n++; end while (!(bus_if.instr_valid && bus_if.instr_pc != 16'hFFFF) && n < 20);
        chk("wrap_pc_0000", bus_if.instr_pc, 16'h0000);
        chk("wrap_instr_0000", bus_if.instr, 16'h2000);

        // Reset with a fetch pending
        lat_mode = 3;
        do_redirect(16'h0010);
        wait_req(16'h0010, 20);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midrst_valid", bus_if.instr_valid, 0);
        chk("midrst_req", bus_if.imem_req, 0);
        chk("midrst_pc", bus_if.imem_addr, RESET_PC);
        wait_req(RESET_PC, 10);
        wait_valid(20);
        chk("midrst_instr_pc", bus_if.instr_pc, RESET_PC);
        chk("midrst_instr", bus_if.instr, 16'h2000);

        // Randomized traffic
        reset = 1'b1; scramble = 1'b1; lat_mode = -1; spur_en = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            bus_if.stall       = ($urandom_range(0, 9) < 3);
            bus_if.redirect    = ($urandom_range(0, 99) < 6);
            bus_if.redirect_pc = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3)))
                                                             : 16'($urandom);
            reset              = ($urandom_range(0, 255) == 0);
            cyc();
        end
        reset = 1'b0; bus_if.stall = 1'b0; bus_if.redirect = 1'b0;
        repeat (10) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
